// File: rtl/countdown_arbiter_if.sv
// countdown_arbiter_if -- request/grant bundle for countdown_arbiter.
//
// Signals (the arbiter sits on the slave side):
//   req0, len0 : requester 0 count request and 3-bit start value
//   req1, len1 : requester 1 count request and 3-bit start value
//   gnt        : one-hot grant (bit i = requester i), 0 when idle
//   done       : one-cycle terminal-count pulse to the served requester
//   busy       : arbiter is not idle
//   q_out      : current value of the shared down counter
//   abort      : cancel the running count (only when COUNTDOWN_ARB_ABORT_EN is defined)
//
// Optional feature macro: COUNTDOWN_ARB_ABORT_EN
interface countdown_arbiter_if;
  logic       req0;
  logic [2:0] len0;
  logic       req1;
  logic [2:0] len1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [2:0] q_out;
`ifdef COUNTDOWN_ARB_ABORT_EN
  logic       abort;
`endif

  // Requester / stimulus side.
  modport master (
    output req0, len0, req1, len1,
`ifdef COUNTDOWN_ARB_ABORT_EN
    output abort,
`endif
    input  gnt, done, busy, q_out
  );

  // Arbiter side.
  modport slave (
    input  req0, len0, req1, len1,
`ifdef COUNTDOWN_ARB_ABORT_EN
    input  abort,
`endif
    output gnt, done, busy, q_out
  );
endinterface

// File: rtl/countdown_arbiter.sv
// countdown_arbiter -- two requesters share one 3-bit down counter.
//
// A round-robin arbiter grants the counter to one requester, loads that
// requester's start value, counts down to zero, pulses done for one cycle
// and returns to idle. All outputs come straight from registers.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : countdown_arbiter_if.slave (req0/len0, req1/len1 in;
//           gnt, done, busy, q_out out; abort in when enabled)
//
// Optional feature macro: COUNTDOWN_ARB_ABORT_EN -- when defined, abort
// high during COUNT cancels the count without a done pulse.
module countdown_arbiter (
  input  logic                  clk,
  input  logic                  reset,
  countdown_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [1:0] gnt_q,   gnt_d;
  logic [1:0] done_q,  done_d;
  logic       busy_q,  busy_d;
  logic       last_q,  last_d;   // index of the requester served last
  logic       pick1;             // requester 1 wins this arbitration

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;           // requester 0 wins the first contention
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    last_d  = last_q;
    // Requester 1 wins when it is alone, or when both ask and 0 went last.
    pick1   = bus.req1 & (~bus.req0 | ~last_q);

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d = COUNT;
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          cnt_d   = pick1 ? bus.len1 : bus.len0;
        end
      end

      COUNT: begin
`ifdef COUNTDOWN_ARB_ABORT_EN
        if (bus.abort) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          cnt_d   = 3'd0;
          last_d  = gnt_q[1];
        end else
`endif
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Terminal count: the done pulse is registered on entry to DONE.
          state_d = DONE;
          done_d  = gnt_q;
        end
      end

      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        last_d  = gnt_q[1];
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        cnt_d   = 3'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.q_out = cnt_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// tb_countdown_arbiter -- directed, table-driven bench for countdown_arbiter.
// Each table row gives the inputs applied before a clock edge and the
// outputs expected just after it; hand-written sequences cover mid-count
// reset and (when COUNTDOWN_ARB_ABORT_EN is defined) abort.
module tb_countdown_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  countdown_arbiter_if bus ();

  countdown_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       r0;
    logic [2:0] l0;
    logic       r1;
    logic [2:0] l1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [2:0] q;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(int rst, int r0, int l0, int r1, int l1,
                              int g, int d, int b, int q);
    vec_t v;
    v.rst = rst[0]; v.r0 = r0[0]; v.l0 = l0[2:0]; v.r1 = r1[0]; v.l1 = l1[2:0];
    v.gnt = g[1:0]; v.done = d[1:0]; v.busy = b[0]; v.q = q[2:0];
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {bus.gnt, bus.done, bus.busy, bus.q_out};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b done=%b busy=%b q=%0d, want gnt=%b done=%b busy=%b q=%0d",
               name, act[7:6], act[5:4], act[3], act[2:0],
               exp[7:6], exp[5:4], exp[3], exp[2:0]);
    end else begin
      $display("ok   %s: gnt=%b done=%b busy=%b q=%0d",
               name, act[7:6], act[5:4], act[3], act[2:0]);
    end
  endtask

  task automatic drive(logic rst, logic r0, logic [2:0] l0, logic r1, logic [2:0] l1);
    reset    = rst;
    bus.req0 = r0;
    bus.len0 = l0;
    bus.req1 = r1;
    bus.len1 = l1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
`ifdef COUNTDOWN_ARB_ABORT_EN
    bus.abort = 1'b0;
`endif

    // ---- reset and single request (len0=3), late input changes ignored
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,3,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,3,0,0, 1,0,1,3));
    vecs.push_back(mk(0,0,5,0,0, 1,0,1,2));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0));
    // ---- simultaneous requests after reset, then fairness over 4 grants
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,2,1,5, 1,0,1,2));
    vecs.push_back(mk(0,1,2,1,5, 1,0,1,1));
    vecs.push_back(mk(0,1,2,1,5, 1,0,1,0));
    vecs.push_back(mk(0,1,2,1,5, 1,1,1,0));
    vecs.push_back(mk(0,1,2,1,5, 0,0,0,0));
    vecs.push_back(mk(0,1,2,1,5, 2,0,1,5));
    vecs.push_back(mk(0,1,2,1,5, 2,0,1,4));
    vecs.push_back(mk(0,1,2,1,5, 2,0,1,3));
    vecs.push_back(mk(0,1,2,1,5, 2,0,1,2));
    vecs.push_back(mk(0,1,2,1,5, 2,0,1,1));
    vecs.push_back(mk(0,1,2,1,5, 2,0,1,0));
    vecs.push_back(mk(0,1,2,1,5, 2,2,1,0));
    vecs.push_back(mk(0,1,2,1,5, 0,0,0,0));
    vecs.push_back(mk(0,1,2,1,5, 1,0,1,2));
    vecs.push_back(mk(0,1,2,1,5, 1,0,1,1));
    vecs.push_back(mk(0,1,2,1,5, 1,0,1,0));
    vecs.push_back(mk(0,1,2,1,5, 1,1,1,0));
    vecs.push_back(mk(0,1,2,1,5, 0,0,0,0));
    vecs.push_back(mk(0,1,2,1,5, 2,0,1,5));
    vecs.push_back(mk(0,0,0,0,0, 2,0,1,4));
    vecs.push_back(mk(0,0,0,0,0, 2,0,1,3));
    vecs.push_back(mk(0,0,0,0,0, 2,0,1,2));
    vecs.push_back(mk(0,0,0,0,0, 2,0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 2,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 2,2,1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0));
    // ---- boundaries: len1=0, then len0=7 with no wrap
    vecs.push_back(mk(0,0,0,1,0, 2,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 2,2,1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,7,0,0, 1,0,1,7));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,6));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,5));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,4));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,3));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,2));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,1,0));
    // ---- request held across its own DONE is re-granted
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 1,0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].l0, vecs[i].r1, vecs[i].l1);
      tick();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].q});
    end

    // ---- mid-count reset at q_out=4: no done pulse afterwards
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    check("mcr_reset", outs(), 8'b00_00_0_000);
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd6);
    tick();
    check("mcr_grant", outs(), 8'b10_00_1_110);
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 8 && bus.q_out != 3'd4; i++) tick();
    check("mcr_at4", outs(), 8'b10_00_1_100);
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    check("mcr_cleared", outs(), 8'b00_00_0_000);
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mcr_quiet%0d", i), outs(), 8'b00_00_0_000);
    end

`ifdef COUNTDOWN_ARB_ABORT_EN
    // ---- abort at q_out=2 with requester 1 pending
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 1'b1, 3'd5, 1'b1, 3'd3);
    tick();
    check("abt_grant", outs(), 8'b01_00_1_101);
    for (int i = 0; i < 8 && bus.q_out != 3'd2; i++) tick();
    check("abt_at2", outs(), 8'b01_00_1_010);
    bus.abort = 1'b1;
    tick();
    check("abt_idle", outs(), 8'b00_00_0_000);
    tick();                       // abort still high in IDLE: ignored
    check("abt_next", outs(), 8'b10_00_1_011);
    bus.abort = 1'b0;
    tick();
    check("abt_runs", outs(), 8'b10_00_1_010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_arbiter.md
COUNTDOWN_ARBITER -- requirements
Module: countdown_arbiter

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, the single rising-edge clock for all state.
REQ-002 The block SHALL have port `reset`: input, 1 bit, synchronous and active-high, sampled on the rising edge of `clk`.
REQ-003 The block SHALL have port `req0`: input, 1 bit, count request from requester 0.
REQ-004 The block SHALL have port `len0`: input, 3 bits, countdown start value for requester 0; valid while `req0` is high.
REQ-005 The block SHALL have port `req1`: input, 1 bit, count request from requester 1.
REQ-006 The block SHALL have port `len1`: input, 3 bits, countdown start value for requester 1; valid while `req1` is high.
REQ-007 The block SHALL have port `gnt`: output, 2 bits, one-hot grant (bit i = requester i), or 0 when idle.
REQ-008 The block SHALL have port `done`: output, 2 bits, one-cycle pulse to the served requester on terminal count.
REQ-009 The block SHALL have port `busy`: output, 1 bit, high whenever state is not IDLE.
REQ-010 The block SHALL have port `q_out`: output, 3 bits, current value of the shared down counter.
REQ-011 The block SHALL have port `abort`: input, 1 bit, present only when COUNTDOWN_ARB_ABORT_EN is defined (see REQ-026).

Function
REQ-012 The block SHALL contain one 3-bit down counter shared by both requesters, sequenced by a 3-state FSM: IDLE, COUNT, DONE.
REQ-013 In IDLE, requests SHALL be sampled each edge; if any `reqi` is high, the next state SHALL be COUNT, `gnt` SHALL become one-hot for the winner, and `q_out` SHALL load the winner's `len`.
REQ-014 Arbitration SHALL be round-robin:
- a sole requester wins;
- when both requesters are high, the one not served last wins;
- the last-served pointer SHALL update when the grant ends.
REQ-015 In COUNT, the counter SHALL behave as follows:
- if `q_out` != 0, `q_out` SHALL decrement by 1 per edge;
- if `q_out` == 0, the next state SHALL be DONE and `q_out` SHALL hold at 0;
- `q_out` SHALL never wrap below 0.
REQ-016 In DONE, `done[i]` SHALL be high for exactly one cycle for the granted requester, and the next state SHALL be IDLE.
REQ-017 `gnt` SHALL stay high through COUNT and DONE, and SHALL clear on the transition to IDLE.
REQ-018 Latency: if IDLE samples a request with len=N at edge k, then:
- `gnt` is high after edge k;
- `done` is high in the cycle after edge k+N+1;
- `gnt` clears and `busy` falls after edge k+N+2;
- the earliest next grant is at edge k+N+3.
REQ-019 A request with len=0 SHALL produce one COUNT cycle followed by DONE.
REQ-020 `reqi`/`leni` changes while not in IDLE SHALL be ignored: the count continues and `len` is captured only at grant.
REQ-021 A request still held in IDLE after its own DONE SHALL be re-arbitrated normally, subject to the round-robin pointer.

Reset
REQ-022 On `reset` high at an edge, the block SHALL set:
- state = IDLE;
- `q_out` = 0, `gnt` = 0, `done` = 0, `busy` = 0;
- last-served pointer = requester 1, so requester 0 wins the first contention.
REQ-023 Reset SHALL take priority over all other inputs, including mid-COUNT; no `done` pulse SHALL be emitted for a count cancelled by reset.
REQ-024 Outputs SHALL be driven from registers only; no combinational path SHALL run from inputs to outputs.

Configuration
REQ-025 Macro COUNTDOWN_ARB_ABORT_EN SHALL control the abort feature.
REQ-026 With COUNTDOWN_ARB_ABORT_EN defined:
- `abort` high in COUNT SHALL force the next state to IDLE, clear `gnt`, set `q_out` to 0, emit no `done`, and update the pointer as if the grant had completed;
- `abort` SHALL be ignored in IDLE and DONE.
REQ-027 With COUNTDOWN_ARB_ABORT_EN undefined, the `abort` port SHALL be absent and every granted count SHALL run to DONE.

Verification
REQ-028 Reset then single request: `req0`=1, `len0`=3 -> `gnt`=01, `q_out` 3,2,1,0, `done`=01 for one cycle, then `busy`=0.
REQ-029 Simultaneous request after reset: `req0`=`req1`=1, `len0`=2, `len1`=5 -> requester 0 served first; requester 1 granted at the next IDLE with `q_out`=5.
REQ-030 Fairness: both requests held continuously for 4 grants -> `gnt` sequence 01,10,01,10, and every grant has exactly one matching `done` pulse.
REQ-031 Boundary: `len1`=0 -> one COUNT cycle, `done`=10, `q_out` stays 0; and `len0`=7 -> 8 COUNT cycles with no wrap.
REQ-032 Mid-count reset: `reset`=1 while `q_out`=4 -> next cycle `q_out`=0, `gnt`=00, `busy`=0, and no `done` pulse.
REQ-033 Abort, with COUNTDOWN_ARB_ABORT_EN defined: `abort`=1 at `q_out`=2 -> IDLE, `gnt`=00, no `done`, and a pending other requester is granted next.
